// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, the
// divide-by-zero quotient constant and the EXE-bus mul_div_op mapping.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Widest supported datapath; the top slices the low WIDTH bits.
  localparam int DIV_MAX_W = 64;

  // Divide-by-zero quotient is all ones regardless of signedness.
  localparam logic [DIV_MAX_W-1:0] DIV_BY_ZERO_Q = '1;

  // mul_div_op index on the EXE bus for the divide family.
  typedef enum logic [1:0] {
    MDU_DIV_W  = 2'd0,
    MDU_MOD_W  = 2'd1,
    MDU_DIV_WU = 2'd2,
    MDU_MOD_WU = 2'd3
  } mul_div_op_e;

  // The .wu variants are the unsigned ones.
  function automatic logic op_is_signed(input mul_div_op_e op);
    return (op == MDU_DIV_W) || (op == MDU_MOD_W);
  endfunction

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor, keep the difference and set the quotient bit
// when there is no borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_bits;

  // Trial subtraction with one extra bit to expose the borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor};
    if (trial[WIDTH+1]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // The partial remainder always fits WIDTH bits, so these top bits are
  // zero whenever they would be kept.
  assign unused_bits = shifted[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider, signed or unsigned per op, with
// valid/ready on both sides, tag pass-through and synchronous flush.
// Optional macro DIV_FAST_PATH_EN: ops with a zero divisor or |a| < |b|
// bypass the iteration and finish in 2 cycles with identical results.
module iter_div_unit
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  div_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r, dividend_r;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [TAG_W-1:0] tag_r;
  logic             q_neg, r_neg, dz;

  logic             a_neg, b_neg, accept, fast, last_iter;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign in_ready  = resetn && (state == DIV_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DIV_DONE);
  assign busy      = (state != DIV_IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH-1));

  assign a_neg = in_signed & in_dividend[WIDTH-1];
  assign b_neg = in_signed & in_divisor[WIDTH-1];
  assign abs_a = a_neg ? -in_dividend : in_dividend;
  assign abs_b = b_neg ? -in_divisor  : in_divisor;

`ifdef DIV_FAST_PATH_EN
  // Quotient magnitude is provably zero: skip straight to sign fix-up.
  assign fast = (in_divisor == '0) || (abs_a < abs_b);
`else
  assign fast = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= DIV_IDLE;
    else         state <= state_n;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: if (accept)    state_n = fast ? DIV_FIX : DIV_ITER;
      DIV_ITER: if (last_iter) state_n = DIV_FIX;
      DIV_FIX:                 state_n = DIV_DONE;
      DIV_DONE: if (out_ready) state_n = DIV_IDLE;
      default:                 state_n = DIV_IDLE;
    endcase
    if (flush) state_n = DIV_IDLE;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt           <= '0;
      rem_r         <= '0;
      quo_r         <= '0;
      dvsr_r        <= '0;
      dividend_r    <= '0;
      tag_r         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      dz            <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (accept) begin
          cnt        <= '0;
          dvsr_r     <= abs_b;
          dividend_r <= in_dividend;
          tag_r      <= in_tag;
          q_neg      <= a_neg ^ b_neg;
          r_neg      <= a_neg;
          dz         <= (in_divisor == '0);
          rem_r      <= fast ? abs_a : '0;
          quo_r      <= fast ? '0    : abs_a;
        end
        DIV_ITER: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt   <= cnt + 1'b1;
        end
        DIV_FIX: begin
          out_quotient  <= dz ? DIV_BY_ZERO_Q[WIDTH-1:0] : (q_neg ? -quo_r : quo_r);
          out_remainder <= dz ? dividend_r : (r_neg ? -rem_r : rem_r);
          out_tag       <= tag_r;
        end
        default: ;
      endcase
    end
  end

endmodule
